quad_dec_ctrl: RTL and testbench
================================

Name: quad_dec_ctrl

Overview:
Quadrature encoder front end that produces the count-enable and direction controls for an N-bit up/down position counter. It also integrates that counter. Raw A/B encoder inputs are synchronized, glitch-filtered and decoded by a Gray-sequence FSM into single-cycle step pulses with direction. It sits between board-level encoder pins and downstream position/velocity logic.

Parameters:
N, 8, width of position register pos
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
FILT_LEN, 4, consecutive identical synchronized samples required before a filtered level changes (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
a_in  input  1  raw encoder channel A (asynchronous to clk)
b_in  input  1  raw encoder channel B (asynchronous to clk)
en  input  1  decode enable; 0 suppresses step/err generation
clr  input  1  synchronous clear of pos and err
step  output  1  one-cycle pulse per valid quadrature transition
dir  output  1  direction of last step: 1=up, 0=down
err  output  1  sticky illegal-transition flag
valid  output  1  high once the first filtered A/B state is captured after reset
pos  output  N  position, modulo 2^N
max_tick  output  1  pos == 2^N-1
min_tick  output  1  pos == 0

Behaviour:
- Reset (asynchronous, active-high, clock clk): synchronizers and filtered levels = 0; filter counters = 0; FSM = INIT; step=0, dir=0, err=0, valid=0, pos=0 (so min_tick=1, max_tick=0).
- Synchronizer: SYNC_STAGES-deep FF chain per channel.
- Filter, per channel: counter tracks consecutive synchronized samples differing from the current filtered level. It clears on any sample equal to the filtered level. When the count reaches FILT_LEN, the filtered level toggles and the counter clears. Pulses shorter than FILT_LEN cycles never propagate.
- FSM states: INIT, S00, S01, S11, S10 (state = last filtered {A,B}).
- INIT: the first cycle after reset release loads the state from the current filtered {A,B}. It moves to the matching Sxx, sets valid=1 and produces no step.
- Up sequence: 00->01->11->10->00. Down sequence: the reverse.
- Single-bit change in the up direction: step=1, dir=1. Single-bit change in the down direction: step=1, dir=0.
- Both bits change in one filtered update: err<=1 (sticky), no step, dir unchanged, state moves to the new value.
- en=0: filter and FSM state keep tracking, step stays 0, err is not set. Re-enabling never generates a spurious step.
- Latency: a clean level change on a_in/b_in produces step in the cycle after the edge at which the filtered level updates. Total latency is SYNC_STAGES+FILT_LEN+1 clocks; default 7.
- step is registered, high for exactly one cycle. dir is registered with step and holds its value between steps.
- pos: +1 on step&dir, -1 on step&~dir, N-bit wrap (2^N-1 +1 -> 0; 0 -1 -> 2^N-1).
- max_tick and min_tick are combinational from pos.
- clr: pos<=0, err<=0 next edge. clr has priority over a simultaneous step; the step pulse and dir still appear on their outputs.
- Reset mid-sequence: all state is discarded, and the FSM re-enters INIT after release.

Optional Feature:
QDEC_INDEX_EN
- Defined: adds input z_in (1 bit, encoder index).
- z_in uses the same synchronizer and filter as A/B.
- A rising edge of filtered z sets pos<=0 on the next edge, with priority over step and equal to clr. err is unaffected.
- Undefined: no z_in port and no index logic.

Test Plan:
- Reset, hold a_in=b_in=0 for 20 cycles -> valid=1 after release, step never asserted, pos=0, min_tick=1, err=0.
- en=1, drive {a,b} 00->01->11->10->00, each held 10 cycles -> four step pulses each 1 cycle wide with dir=1, each 7 cycles after its input change; pos=4.
- From pos=0 drive 00->10 -> one step with dir=0, pos=255, max_tick=1.
- Pulse a_in high for 3 cycles (FILT_LEN=4) -> no step, pos unchanged. Hold a_in high for 4+ cycles -> exactly one step.
- Drive 00->11 in one cycle -> err=1, no step, pos unchanged. Then assert clr with a simultaneous valid step -> pos=0, err=0, step still pulses.
- en=0 while rotating 3 transitions, then en=1 -> no steps during en=0 and none on re-enable. With QDEC_INDEX_EN defined, a z_in pulse held 6 cycles at pos=37 -> pos=0.

Source files
------------

// File: rtl/quad_dec_ctrl.sv
// Quadrature encoder front end: synchronizer, glitch filter, Gray-sequence decoder and position counter.
// Optional index input z_in (clears pos on filtered rising edge) enabled by defining QDEC_INDEX_EN.
module quad_dec_ctrl #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_in,
  input  logic         b_in,
`ifdef QDEC_INDEX_EN
  input  logic         z_in,
`endif
  input  logic         en,
  input  logic         clr,
  output logic         step,
  output logic         dir,
  output logic         err,
  output logic         valid,
  output logic [N-1:0] pos,
  output logic         max_tick,
  output logic         min_tick
);

`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
  logic [NCH-1:0] raw;
  assign raw = {z_in, b_in, a_in};
`else
  localparam int NCH = 2;
  logic [NCH-1:0] raw;
  assign raw = {b_in, a_in};
`endif

  localparam int CW = $clog2(FILT_LEN + 1);

  localparam logic [2:0] S00  = 3'b000;
  localparam logic [2:0] S01  = 3'b001;
  localparam logic [2:0] S11  = 3'b011;
  localparam logic [2:0] S10  = 3'b010;
  localparam logic [2:0] INIT = 3'b100;

  function automatic logic [1:0] up_next(input logic [1:0] s);
    case (s)
      2'b00:   up_next = 2'b01;
      2'b01:   up_next = 2'b11;
      2'b11:   up_next = 2'b10;
      default: up_next = 2'b00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
  logic [NCH-1:0]                  smp;
  logic [NCH-1:0][CW-1:0]          cnt;
  logic [NCH-1:0]                  filt;
  logic [1:0]                      ab;
  logic [2:0]                      state, state_nxt;
  logic                            step_d, dir_d, err_set;
  logic                            idx_clr;

  // Synchronizer stage: SYNC_STAGES-deep shift per channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign smp = sync_q[SYNC_STAGES-1];

  // Filter stage: level flips only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (smp[c] == filt[c]) begin
          cnt[c] <= '0;
        end else if (cnt[c] == CW'(FILT_LEN - 1)) begin
          filt[c] <= ~filt[c];
          cnt[c]  <= '0;
        end else begin
          cnt[c] <= cnt[c] + CW'(1);
        end
      end
    end
  end

  assign ab = {filt[0], filt[1]};

`ifdef QDEC_INDEX_EN
  logic z_prev;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) z_prev <= 1'b0;
    else       z_prev <= filt[2];
  end
  assign idx_clr = filt[2] & ~z_prev;
`else
  assign idx_clr = 1'b0;
`endif

  // Decode stage: state always follows the filtered {A,B}, even while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = {1'b0, ab};
  end

  always_comb begin
    step_d  = 1'b0;
    dir_d   = dir;
    err_set = 1'b0;
    if (en && state != INIT && ab != state[1:0]) begin
      if (ab == (state[1:0] ^ 2'b11)) begin
        err_set = 1'b1;
      end else begin
        step_d = 1'b1;
        dir_d  = (ab == up_next(state[1:0]));
      end
    end
  end

  assign valid = (state != INIT);

  // Output stage: registered step/dir, sticky err, position counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step <= 1'b0;
      dir  <= 1'b0;
      err  <= 1'b0;
      pos  <= '0;
    end else begin
      step <= step_d;
      dir  <= dir_d;
      if (clr)          err <= 1'b0;
      else if (err_set) err <= 1'b1;
      if (clr || idx_clr) pos <= '0;
      else if (step)      pos <= dir ? pos + N'(1) : pos - N'(1);
    end
  end

  assign max_tick = &pos;
  assign min_tick = ~|pos;

endmodule

// File: tb/tb_quad_dec_ctrl.sv
// Directed bench for quad_dec_ctrl with default parameters (N=8, SYNC_STAGES=2, FILT_LEN=4).
module tb_quad_dec_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0, b_in = 1'b0, z_in = 1'b0;
  logic       en = 1'b1, clr = 1'b0;
  logic       step, dir, err, valid, max_tick, min_tick;
  logic [7:0] pos;

  int checks = 0, errors = 0;
  int cyc = 0, nsteps = 0, nwide = 0, last_cyc = 0;
  logic step_prev = 1'b0;

  quad_dec_ctrl #(.N(8), .SYNC_STAGES(2), .FILT_LEN(4)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
`ifdef QDEC_INDEX_EN
    .z_in(z_in),
`endif
    .en(en), .clr(clr), .step(step), .dir(dir), .err(err), .valid(valid),
    .pos(pos), .max_tick(max_tick), .min_tick(min_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step) begin
      nsteps   = nsteps + 1;
      last_cyc = cyc;
      if (step_prev) nwide = nwide + 1;
    end
    step_prev = step;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic move(input logic a, input logic b, input int exp_n, input logic exp_dir,
                      input string tag);
    int n0, t0;
    @(posedge clk); #1;
    a_in = a; b_in = b; n0 = nsteps; t0 = cyc;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk({tag, "_steps"}, nsteps - n0, exp_n);
    if (exp_n == 1) begin
      chk({tag, "_lat"}, last_cyc - t0, 7);
      chk({tag, "_dir"}, dir, exp_dir);
    end
  endtask

  initial begin
    int n0;
    logic [1:0] up_seq [4];
    up_seq[0] = 2'b00; up_seq[1] = 2'b01; up_seq[2] = 2'b11; up_seq[3] = 2'b10;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_pos", pos, 0);
    chk("rst_min", min_tick, 1);
    chk("rst_max", max_tick, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_valid", valid, 1);
    chk("idle_steps", nsteps, 0);
    chk("idle_pos", pos, 0);
    chk("idle_min", min_tick, 1);
    chk("idle_err", err, 0);

    // up sequence
    move(1'b0, 1'b1, 1, 1'b1, "up01");
    move(1'b1, 1'b1, 1, 1'b1, "up11");
    move(1'b1, 1'b0, 1, 1'b1, "up10");
    move(1'b0, 1'b0, 1, 1'b1, "up00");
    chk("up_pos", pos, 4);

    // clear, then one down step wraps to 255
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_pos", pos, 0);
    move(1'b1, 1'b0, 1, 1'b0, "dn10");
    chk("wrap_pos", pos, 255);
    chk("wrap_max", max_tick, 1);
    chk("wrap_min", min_tick, 0);

    // 3-cycle glitch on a is rejected, a real change is accepted
    @(posedge clk); #1 a_in = 1'b0;
    repeat (3) @(posedge clk); #1 a_in = 1'b1;
    n0 = nsteps;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("glitch_steps", nsteps - n0, 0);
    chk("glitch_pos", pos, 255);
    move(1'b0, 1'b0, 1, 1'b1, "hold00");
    chk("hold_pos", pos, 0);

    // illegal double transition
    move(1'b1, 1'b1, 0, 1'b1, "dbl11");
    chk("dbl_err", err, 1);
    chk("dbl_dir", dir, 1);
    chk("dbl_pos", pos, 0);

    // clr coincident with a step: clr wins on pos, step still pulses
    @(posedge clk); #1;
    a_in = 1'b1; b_in = 1'b0; n0 = nsteps;
    repeat (7) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("clrstep_steps", nsteps - n0, 1);
    chk("clrstep_pos", pos, 0);
    chk("clrstep_err", err, 0);

    // disabled rotation: no steps, none on re-enable, state keeps tracking
    @(posedge clk); #1 en = 1'b0;
    move(1'b0, 1'b0, 0, 1'b1, "dis00");
    move(1'b0, 1'b1, 0, 1'b1, "dis01");
    move(1'b1, 1'b1, 0, 1'b1, "dis11");
    n0 = nsteps;
    @(posedge clk); #1 en = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("reen_steps", nsteps - n0, 0);
    chk("dis_pos", pos, 0);
    chk("dis_err", err, 0);
    move(1'b1, 1'b0, 1, 1'b1, "reen10");
    chk("reen_pos", pos, 1);

    // walk up to pos=37
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      a_in = up_seq[i % 4][1]; b_in = up_seq[i % 4][0];
      repeat (9) @(posedge clk);
    end
    @(negedge clk);
    chk("walk_pos", pos, 37);
    chk("wide_pulses", nwide, 0);

`ifdef QDEC_INDEX_EN
    @(posedge clk); #1 z_in = 1'b1;
    repeat (6) @(posedge clk); #1 z_in = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("index_pos", pos, 0);
`endif

    // reset mid-run
    @(posedge clk); #1;
    a_in = 1'b0; b_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_pos", pos, 0);
    chk("mid_rst_min", min_tick, 1);
    chk("mid_rst_step", step, 0);
    chk("mid_rst_dir", dir, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n0 = nsteps;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_rel_valid", valid, 1);
    chk("mid_rel_steps", nsteps - n0, 0);
    chk("mid_rel_pos", pos, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
